// File: rtl/rr_priority_arbiter_pkg.sv
// Shared definitions for the rr_priority_arbiter block: FSM encoding,
// selection-mode strings and a constant log2 helper.
package rr_priority_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam string MODE_RR    = "RR";
    localparam string MODE_FIXED = "FIXED";
    localparam string PRIO_MSB   = "MSB";
    localparam string PRIO_LSB   = "LSB";

    // Ceiling log2. Returns the number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter_rr_mask_encoder.sv
// rr_mask_encoder: combinational winner search for the arbiter.
// One bit of the request vector can be masked out (the outgoing owner).
// The masked vector is duplicated, shifted right by the start pointer and
// scanned for its lowest set bit, so the search wraps WIDTH-1 -> 0 for free.
// With REVERSE set the vector is bit-reversed before the scan and the index
// mirrored afterwards, turning a lowest-first search into highest-first.
module rr_mask_encoder
    import rr_priority_arbiter_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter bit  REVERSE = 1'b0,
    localparam int IW      = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IW-1:0]    start_ptr,
    input  logic [IW-1:0]    mask_idx,
    input  logic             mask_en,
    output logic [IW-1:0]    winner,
    output logic             any_valid
);

    logic [WIDTH-1:0]   mask_vec_s;
    logic [WIDTH-1:0]   masked_s;
    logic [WIDTH-1:0]   ordered_s;
    logic [2*WIDTH-1:0] doubled_s;
    logic [WIDTH-1:0]   rotated_s;
    logic [IW-1:0]      offset_s;
    logic [IW-1:0]      pos_s;

    // Mask the owner bit, optionally mirror, then rotate so start_ptr lands at bit 0
    always_comb begin
        mask_vec_s = {{(WIDTH-1){1'b0}}, mask_en} << mask_idx;
        masked_s   = vec & ~mask_vec_s;
        for (int i = 0; i < WIDTH; i++) begin
            ordered_s[i] = REVERSE ? masked_s[WIDTH-1-i] : masked_s[i];
        end
        doubled_s = {ordered_s, ordered_s};
        rotated_s = WIDTH'(doubled_s >> start_ptr);
        any_valid = |ordered_s;
    end

    // Find the lowest set bit of the rotated vector and map it back to an index
    always_comb begin
        offset_s = {IW{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            offset_s = rotated_s[i] ? IW'(i) : offset_s;
        end
        pos_s  = offset_s + start_ptr;
        winner = REVERSE ? (IW'(WIDTH - 1) - pos_s) : pos_s;
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: registered N-way arbiter with ownership handshake.
// A requester keeps its grant until it releases or drops its request; the
// next owner is chosen on that same edge with the outgoing owner excluded.
// Selection is round-robin (MODE="RR") or fixed priority (MODE="FIXED",
// PRIORITY="MSB"/"LSB").
// Optional feature macro: ARB_TIMEOUT_EN -- forces end of ownership after
// MAX_HOLD cycles and pulses 'timeout'. Without it timeout is constant 0.
// The release input is named release_in because 'release' is a reserved word.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int    WIDTH    = 8,
    parameter string MODE     = "RR",
    parameter string PRIORITY = "MSB",
    parameter int    MAX_HOLD = 16,
    localparam int   IW       = clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] request,
    input  logic             release_in,
    output logic [WIDTH-1:0] grant,
    output logic [IW-1:0]    grant_id,
    output logic             grant_valid,
    output logic             timeout
);

    localparam bit IS_RR   = (MODE == MODE_RR);
    localparam bit REVERSE = !IS_RR && (PRIORITY == PRIO_MSB);

    arb_state_t       state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             owner_done_s;
    logic             forced_s;
    logic             limit_hit_s;
    logic             new_grant_s;
    logic [IW-1:0]    start_ptr_s;
    logic [IW-1:0]    win_id_s;
    logic             win_any_s;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = clog2(MAX_HOLD);
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Detect end of ownership: explicit release, dropped request or hold limit
    always_comb begin
        limit_hit_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
        limit_hit_s = (hold_cnt_q == HW'(MAX_HOLD - 1));
`endif
        if (state_q == ST_GRANT) begin
            owner_done_s = release_in | ~request[grant_id_q] | limit_hit_s;
            forced_s     = limit_hit_s & ~release_in & request[grant_id_q];
        end else begin
            owner_done_s = 1'b0;
            forced_s     = 1'b0;
        end
        start_ptr_s = IS_RR ? rr_ptr_q : {IW{1'b0}};
    end

    rr_mask_encoder #(
        .WIDTH   (WIDTH),
        .REVERSE (REVERSE)
    ) u_encoder (
        .vec       (request),
        .start_ptr (start_ptr_s),
        .mask_idx  (grant_id_q),
        .mask_en   (owner_done_s),
        .winner    (win_id_s),
        .any_valid (win_any_s)
    );

    // Next-state logic for the IDLE/GRANT ownership FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any_s) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (owner_done_s && !win_any_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and pointer updates: load a new owner, drop to idle or hold
    always_comb begin
        new_grant_s   = win_any_s & ((state_q == ST_IDLE) | owner_done_s);
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        rr_ptr_d      = rr_ptr_q;
        timeout_d     = forced_s;
        if (new_grant_s) begin
            grant_d       = {{(WIDTH-1){1'b0}}, 1'b1} << win_id_s;
            grant_id_d    = win_id_s;
            grant_valid_d = 1'b1;
            rr_ptr_d      = IS_RR ? (win_id_s + IW'(1)) : {IW{1'b0}};
        end else if (owner_done_s) begin
            grant_d       = {WIDTH{1'b0}};
            grant_valid_d = 1'b0;
        end else begin
            grant_d       = grant_q;
            grant_valid_d = grant_valid_q;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter: restarts on each new owner, counts while ownership continues
    always_comb begin
        if (new_grant_s) begin
            hold_cnt_d = {HW{1'b0}};
        end else if (state_q == ST_GRANT && !owner_done_s) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
            hold_cnt_d = {HW{1'b0}};
        end
    end

    // Hold counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_q <= {HW{1'b0}};
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // State, output and pointer registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= {WIDTH{1'b0}};
            grant_id_q    <= {IW{1'b0}};
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            rr_ptr_q      <= {IW{1'b0}};
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
